// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - serial-to-parallel deserializer with valid/ready output and sticky errors
// Synchronizes an asynchronous sin/sen pair and assembles MSB-first WIDTH-bit words.

module serial_deser_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

module serial_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sen,
  input  logic             dready,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic sin_m, sin_s;
  logic sen_m, sen_s;

  serial_deser_dff u_sin_m (.clk(clk), .rst(rst), .d(sin),   .q(sin_m));
  serial_deser_dff u_sin_s (.clk(clk), .rst(rst), .d(sin_m), .q(sin_s));
  serial_deser_dff u_sen_m (.clk(clk), .rst(rst), .d(sen),   .q(sen_m));
  serial_deser_dff u_sen_s (.clk(clk), .rst(rst), .d(sen_m), .q(sen_s));

  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             can_load;
  logic             set_ovr;
  logic             set_ferr;

  assign word     = {shreg, sin_s};
  assign complete = sen_s && (cnt == LAST);
  assign can_load = !dvalid || dready;
  assign set_ovr  = complete && !can_load;
  // Dropping sen between frames (cnt=0) is the normal idle case, not an error.
  assign set_ferr = !sen_s && (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      shreg     <= '0;
      dout      <= '0;
      dvalid    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (sen_s) begin
        shreg <= word[WIDTH-2:0];
        cnt   <= complete ? '0 : cnt + CW'(1);
      end else begin
        cnt   <= '0;
      end

      if (complete) begin
        if (can_load) begin
          dout   <= word;
          dvalid <= 1'b1;
        end
      end else if (dvalid && dready) begin
        dvalid <= 1'b0;
      end

      // A set event in the same cycle as clr must win.
      overrun   <= (overrun   && !clr) || set_ovr;
      frame_err <= (frame_err && !clr) || set_ferr;
    end
  end

endmodule
